// File: rtl/ps2_mouse_init_seq_if.sv
// Handshake bundle between the PS/2 init sequencer, its controller and the PS/2 tx/rx pair.
// The master side drives start and the tx/rx status; the slave side is the sequencer.
interface ps2_mouse_init_seq_if;
  logic       start;
  logic [7:0] tx_cmd;
  logic       tx_send;
  logic       tx_done;
  logic       tx_timeout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       init_done;
  logic       init_error;
  logic [3:0] state_dbg;

  modport master (
    output start, tx_done, tx_timeout, rx_data, rx_valid,
    input  tx_cmd, tx_send, busy, init_done, init_error, state_dbg
  );

  modport slave (
    input  start, tx_done, tx_timeout, rx_data, rx_valid,
    output tx_cmd, tx_send, busy, init_done, init_error, state_dbg
  );
endinterface

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse power-up sequencer: reset 0xFF, expect FA/AA/00, enable 0xF4, expect FA.
// Define PS2_INIT_RETRY_EN to restart the full sequence on failure up to MAX_RETRY times.
//
// state        | meaning
// IDLE         | waiting for start
// SEND_RST     | one-cycle send of 0xFF
// WAIT_TX_RST  | waiting for transmitter to finish 0xFF
// WAIT_ACK_RST | waiting for 0xFA
// WAIT_BAT     | waiting for self-test pass 0xAA (long timeout)
// WAIT_ID      | waiting for device id 0x00
// SEND_EN      | one-cycle send of 0xF4
// WAIT_TX_EN   | waiting for transmitter to finish 0xF4
// WAIT_ACK_EN  | waiting for 0xFA
// DONE         | streaming enabled
// ERROR        | initialization failed
module ps2_mouse_init_seq #(
  parameter int ACK_TIMEOUT = 320000,
  parameter int BAT_TIMEOUT = 12000000,
  parameter int MAX_RETRY   = 3
) (
  input logic clk,
  input logic reset,
  ps2_mouse_init_seq_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SEND_RST     = 4'd1,
    WAIT_TX_RST  = 4'd2,
    WAIT_ACK_RST = 4'd3,
    WAIT_BAT     = 4'd4,
    WAIT_ID      = 4'd5,
    SEND_EN      = 4'd6,
    WAIT_TX_EN   = 4'd7,
    WAIT_ACK_EN  = 4'd8,
    DONE         = 4'd9,
    ERROR        = 4'd10
  } state_t;

  localparam logic [23:0] ACK_LIM = 24'(ACK_TIMEOUT - 1);
  localparam logic [23:0] BAT_LIM = 24'(BAT_TIMEOUT - 1);

  state_t      state, state_nx, fail_nx;
  logic [23:0] cnt;
  logic        expired, fail;

`ifdef PS2_INIT_RETRY_EN
  logic [7:0] retry_cnt;
  logic       retry_ok;

  assign retry_ok = retry_cnt < 8'(MAX_RETRY);
  assign fail_nx  = retry_ok ? SEND_RST : ERROR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retry_cnt <= '0;
    else if (state_nx == DONE || ((state == DONE || state == ERROR) && bus.start))
      retry_cnt <= '0;
    else if (fail && retry_ok)
      retry_cnt <= retry_cnt + 8'd1;
  end
`else
  assign fail_nx = ERROR;
`endif

  assign expired = (cnt == ((state == WAIT_BAT) ? BAT_LIM : ACK_LIM));

  // A received byte always wins over a coincident expiry; a tx timeout wins over tx_done.
  always_comb begin
    state_nx = state;
    fail     = 1'b0;
    case (state)
      IDLE:         if (bus.start) state_nx = SEND_RST;
      SEND_RST:     state_nx = WAIT_TX_RST;
      WAIT_TX_RST: begin
        if (bus.tx_timeout)   fail = 1'b1;
        else if (bus.tx_done) state_nx = WAIT_ACK_RST;
        else if (expired)     fail = 1'b1;
      end
      WAIT_ACK_RST: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hFA) state_nx = WAIT_BAT;
          else                      fail = 1'b1;
        end else if (expired) fail = 1'b1;
      end
      WAIT_BAT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hAA) state_nx = WAIT_ID;
          else                      fail = 1'b1;
        end else if (expired) fail = 1'b1;
      end
      WAIT_ID: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h00) state_nx = SEND_EN;
          else                      fail = 1'b1;
        end else if (expired) fail = 1'b1;
      end
      SEND_EN:      state_nx = WAIT_TX_EN;
      WAIT_TX_EN: begin
        if (bus.tx_timeout)   fail = 1'b1;
        else if (bus.tx_done) state_nx = WAIT_ACK_EN;
        else if (expired)     fail = 1'b1;
      end
      WAIT_ACK_EN: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'hFA) state_nx = DONE;
          else                      fail = 1'b1;
        end else if (expired) fail = 1'b1;
      end
      DONE, ERROR:  if (bus.start) state_nx = SEND_RST;
      default:      state_nx = IDLE;
    endcase
    if (fail) state_nx = fail_nx;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.tx_cmd     <= 8'h00;
      bus.tx_send    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.init_done  <= 1'b0;
      bus.init_error <= 1'b0;
      bus.state_dbg  <= 4'd0;
    end else begin
      state          <= state_nx;
      cnt            <= (state_nx != state) ? '0 : cnt + 24'd1;
      bus.tx_send    <= (state_nx == SEND_RST) || (state_nx == SEND_EN);
      if (state_nx == SEND_RST)     bus.tx_cmd <= 8'hFF;
      else if (state_nx == SEND_EN) bus.tx_cmd <= 8'hF4;
      bus.busy       <= (state_nx != IDLE) && (state_nx != DONE) && (state_nx != ERROR);
      bus.init_done  <= (state_nx == DONE);
      bus.init_error <= (state_nx == ERROR);
      bus.state_dbg  <= state_nx;
    end
  end
endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench for ps2_mouse_init_seq: directed boundary steps, then random failure scenarios
// predicted by an attempt-level model of the retry/abort policy.
module tb_ps2_mouse_init_seq;
  localparam int ACK_T = 100;
  localparam int BAT_T = 300;
  localparam int MAX_R = 3;
`ifdef PS2_INIT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_init_seq_if bus();
  ps2_mouse_init_seq #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAX_R)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  int dbl = 0;
  logic [7:0] sent_q[$];
  logic       prev_send = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_att;
  bit         exp_done;

  // Record every command actually launched and catch multi-cycle send pulses.
  always @(posedge clk) begin
    if (bus.tx_send === 1'b1) sent_q.push_back(bus.tx_cmd);
    if (bus.tx_send === 1'b1 && prev_send === 1'b1) dbl <= dbl + 1;
    prev_send <= bus.tx_send;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_tx(input bit done, input bit tout);
    bus.tx_done = done; bus.tx_timeout = tout; tick();
    bus.tx_done = 1'b0; bus.tx_timeout = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
  endtask

  task automatic wait_send(input string tag);
    int n = 0;
    while (bus.tx_send !== 1'b1 && n < 1000) begin tick(); n++; end
    check(tag, 32'(bus.tx_send), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin tick(); n++; end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  // Transmit phase: kind 0 = tx_timeout, 1 = tx_done with tx_timeout, 2 = silence until expiry.
  task automatic do_tx(input bit fail, input int kind);
    tick();
    repeat ($urandom_range(0, 5)) tick();
    if (!fail)          pulse_tx(1'b1, 1'b0);
    else if (kind == 0) pulse_tx(1'b0, 1'b1);
    else if (kind == 1) pulse_tx(1'b1, 1'b1);
  endtask

  // Response phase: kind 0 = resend/BAT-error byte, 1 = random wrong byte, 2 = silence.
  task automatic do_byte(input logic [7:0] exp, input bit fail, input int kind);
    logic [7:0] b;
    repeat ($urandom_range(0, 6)) tick();
    if (!fail) send_byte(exp);
    else if (kind == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'hFE : 8'hFC);
    else if (kind == 1) begin
      b = 8'($urandom_range(0, 255));
      if (b == exp) b = b ^ 8'h01;
      send_byte(b);
    end
  endtask

  // Entered in the SEND_RST cycle; fs is the stage that fails (6 = none).
  task automatic run_attempt(input int fs, input int kind);
    do_tx(fs == 0, kind);             if (fs == 0) return;
    do_byte(8'hFA, fs == 1, kind);    if (fs == 1) return;
    do_byte(8'hAA, fs == 2, kind);    if (fs == 2) return;
    do_byte(8'h00, fs == 3, kind);    if (fs == 3) return;
    wait_send("scn_send_en");
    do_tx(fs == 4, kind);             if (fs == 4) return;
    do_byte(8'hFA, fs == 5, kind);
  endtask

  // Attempt-level policy: each attempt launches 0xFF, launches 0xF4 if it got past the ID,
  // and a failure either restarts (retry enabled, budget left) or ends in error.
  function automatic void model(input int fs[MAX_R+1]);
    int retries = 0;
    exp_q.delete();
    exp_att  = 0;
    exp_done = 1'b0;
    for (int a = 0; a <= MAX_R; a++) begin
      exp_att++;
      exp_q.push_back(8'hFF);
      if (fs[a] >= 4) exp_q.push_back(8'hF4);
      if (fs[a] == 6) begin exp_done = 1'b1; break; end
      if (!RETRY || retries == MAX_R) break;
      retries++;
    end
  endfunction

  initial begin
    bus.start = 1'b0; bus.tx_done = 1'b0; bus.tx_timeout = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    check("rst_cmd", 32'(bus.tx_cmd), 32'h00);
    check("rst_send", 32'(bus.tx_send), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.init_done), 32'd0);
    check("rst_error", 32'(bus.init_error), 32'd0);
    reset = 1'b0; tick();

    send_byte(8'hFA);
    check("idle_ignore_rx", 32'(bus.state_dbg), 32'd0);

    // Happy path with latency and pulse-width checks.
    pulse_start();
    check("lat_send", 32'(bus.tx_send), 32'd1);
    check("lat_cmd", 32'(bus.tx_cmd), 32'hFF);
    check("lat_state", 32'(bus.state_dbg), 32'd1);
    tick();
    check("send_one_cycle", 32'(bus.tx_send), 32'd0);
    check("wait_tx_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hFA);
    check("wait_tx_ignore_rx", 32'(bus.state_dbg), 32'd2);
    repeat (3) tick();
    pulse_tx(1'b1, 1'b0);
    check("ack_rst_state", 32'(bus.state_dbg), 32'd3);
    pulse_start();
    check("start_ignored_busy", 32'(bus.state_dbg), 32'd3);
    send_byte(8'hFA);
    check("bat_state", 32'(bus.state_dbg), 32'd4);
    send_byte(8'hAA);
    check("id_state", 32'(bus.state_dbg), 32'd5);
    send_byte(8'h00);
    check("send_en_state", 32'(bus.state_dbg), 32'd6);
    check("send_en_pulse", 32'(bus.tx_send), 32'd1);
    check("send_en_cmd", 32'(bus.tx_cmd), 32'hF4);
    tick();
    check("en_cmd_stable", 32'(bus.tx_cmd), 32'hF4);
    check("en_send_low", 32'(bus.tx_send), 32'd0);
    repeat (3) tick();
    pulse_tx(1'b1, 1'b0);
    check("ack_en_state", 32'(bus.state_dbg), 32'd8);
    send_byte(8'hFA);
    check("done_state", 32'(bus.state_dbg), 32'd9);
    check("done_flag", 32'(bus.init_done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);

    // Restart from DONE, then transmit timeout.
    pulse_start();
    check("restart_clears_done", 32'(bus.init_done), 32'd0);
    check("restart_state", 32'(bus.state_dbg), 32'd1);
    tick();
    pulse_tx(1'b0, 1'b1);
    check("tx_timeout_state", 32'(bus.state_dbg), RETRY ? 32'd1 : 32'd10);
    check("tx_timeout_error", 32'(bus.init_error), RETRY ? 32'd0 : 32'd1);
    do_reset();

    // Counter expiry boundary in WAIT_TX_RST.
    pulse_start();
    tick();
    repeat (ACK_T - 1) tick();
    check("expiry_not_yet", 32'(bus.state_dbg), 32'd2);
    tick();
    check("expiry_hit", 32'(bus.state_dbg), RETRY ? 32'd1 : 32'd10);
    do_reset();

    // BAT uses the long limit; byte on the expiry cycle still counts (BAT and ACK_EN).
    pulse_start();
    tick();
    pulse_tx(1'b1, 1'b0);
    send_byte(8'hFA);
    repeat (BAT_T - 1) tick();
    check("bat_long_limit", 32'(bus.state_dbg), 32'd4);
    send_byte(8'hAA);
    check("bat_collision", 32'(bus.state_dbg), 32'd5);
    send_byte(8'h00);
    tick();
    pulse_tx(1'b1, 1'b0);
    repeat (ACK_T - 1) tick();
    check("ack_en_last_cycle", 32'(bus.state_dbg), 32'd8);
    send_byte(8'hFA);
    check("ack_en_collision", 32'(bus.state_dbg), 32'd9);

    // Asynchronous reset in WAIT_ID.
    pulse_start();
    tick();
    pulse_tx(1'b1, 1'b0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("mid_reset_pre", 32'(bus.state_dbg), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.state_dbg), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_cmd", 32'(bus.tx_cmd), 32'h00);
    check("async_rst_send", 32'(bus.tx_send), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_idle", 32'(bus.state_dbg), 32'd0);
    pulse_start();
    check("post_rst_cmd", 32'(bus.tx_cmd), 32'hFF);
    check("post_rst_send", 32'(bus.tx_send), 32'd1);
    do_reset();

    // Random failure scenarios against the attempt-level model.
    for (int s = 0; s < 10; s++) begin
      int fs[MAX_R+1];
      int kd[MAX_R+1];
      for (int a = 0; a <= MAX_R; a++) begin
        fs[a] = ($urandom_range(0, 2) == 0) ? 6 : int'($urandom_range(0, 5));
        kd[a] = int'($urandom_range(0, 2));
      end
      model(fs);
      sent_q.delete();
      pulse_start();
      for (int a = 0; a < exp_att; a++) begin
        wait_send("scn_send_rst");
        run_attempt(fs[a], kd[a]);
      end
      wait_idle();
      tick();
      check("scn_state", 32'(bus.state_dbg), exp_done ? 32'd9 : 32'd10);
      check("scn_done", 32'(bus.init_done), 32'(exp_done));
      check("scn_error", 32'(bus.init_error), 32'(!exp_done));
      check("scn_n_cmd", 32'(sent_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
        check("scn_cmd", 32'(sent_q[i]), 32'(exp_q[i]));
    end

    check("single_cycle_send", 32'(dbl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
